stream_token_src: RTL and testbench

STREAM_TOKEN_SRC -- requirements
Module: stream_token_src

---
 rtl/stream_token_src.sv | 142 ++++++++++++++
 tb/tb_stream_token_src.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_token_src.sv
// Token source: loads a sequence of 17-bit tokens into a small buffer, then
// replays it TX_NUM times on a valid/ready stream, closing with a done token.
module stream_token_src #(
  parameter int DEPTH  = 16,
  parameter int TX_NUM = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic        flush,
  input  logic        tile_en,
  input  logic [16:0] wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic        start,
  output logic [16:0] data_out,
  output logic        data_out_valid,
  input  logic        data_out_ready,
  output logic        done,
  output logic [15:0] tx_count,
  output logic [1:0]  state_dbg
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int RW = (TX_NUM > 1) ? $clog2(TX_NUM) : 1;
  localparam logic [16:0]   DONE_TOKEN = 17'h10100;
  localparam logic [CW-1:0] FULL       = CW'(DEPTH);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_PLAY     = 2'd1;
  localparam logic [1:0] S_DONE_TOK = 2'd2;
  localparam logic [1:0] S_FIN      = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] count;
  logic [AW-1:0] rd_ptr;
  logic [RW-1:0] rep;
  logic          valid_q;
  logic [16:0]   mem [DEPTH];

  logic          wr_fire;
  logic          out_fire;
  logic          last_tok;
  logic          last_rep;
  logic [AW-1:0] next_rd;
  logic [15:0]   tx_next;

  // Handshake: a beat transfers on a rising edge where valid, ready and
  // clk_en are all 1; tile_en=0 forces both ready and valid low.
  assign wr_ready       = tile_en && (state == S_IDLE) && (count != FULL);
  assign data_out_valid = valid_q && tile_en;
  assign wr_fire        = clk_en && wr_valid && wr_ready;
  assign out_fire       = clk_en && data_out_valid && data_out_ready;

  assign last_tok  = (CW'(rd_ptr) == count - CW'(1));
  assign last_rep  = (rep == RW'(TX_NUM - 1));
  assign next_rd   = rd_ptr + AW'(1);
  assign tx_next   = (tx_count == 16'hFFFF) ? tx_count : tx_count + 16'd1;
  assign state_dbg = state;

  // Buffer storage is deliberately unreset; count gates what is reachable.
  always_ff @(posedge clk) begin
    if (wr_fire && !rst) mem[count[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      count    <= '0;
      rd_ptr   <= '0;
      rep      <= '0;
      tx_count <= '0;
      valid_q  <= 1'b0;
      data_out <= '0;
      done     <= 1'b0;
    end else if (clk_en) begin
      if (flush) begin
        state    <= S_IDLE;
        rd_ptr   <= '0;
        rep      <= '0;
        tx_count <= '0;
        valid_q  <= 1'b0;
        done     <= 1'b0;
      end else if (tile_en) begin
        case (state)
          S_IDLE: begin
            if (wr_fire) count <= count + CW'(1);
            if (start) begin
              rd_ptr   <= '0;
              rep      <= '0;
              tx_count <= '0;
              valid_q  <= 1'b1;
              if (count != '0) begin
                state    <= S_PLAY;
                data_out <= mem[0];
              end else begin
                state    <= S_DONE_TOK;
                data_out <= DONE_TOKEN;
              end
            end
          end
          S_PLAY: begin
            if (out_fire) begin
              tx_count <= tx_next;
              // Preload the following token so the stream never bubbles.
              if (last_tok) begin
                rd_ptr <= '0;
                if (last_rep) begin
                  state    <= S_DONE_TOK;
                  data_out <= DONE_TOKEN;
                end else begin
                  rep      <= rep + RW'(1);
                  data_out <= mem[0];
                end
              end else begin
                rd_ptr   <= next_rd;
                data_out <= mem[next_rd];
              end
            end
          end
          S_DONE_TOK: begin
            if (out_fire) begin
              state    <= S_FIN;
              tx_count <= tx_next;
              valid_q  <= 1'b0;
              done     <= 1'b1;
            end
          end
          S_FIN: begin
            if (start) begin
              state <= S_IDLE;
              done  <= 1'b0;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stream_token_src.sv
// Bench for stream_token_src: two instances (TX_NUM=1 and TX_NUM=2) share all
// inputs; a queue-based reference of the expected token stream checks both.
module tb_stream_token_src;

  localparam int          DEPTH    = 16;
  localparam logic [16:0] DONE_TOK = 17'h10100;

  logic        clk = 1'b0;
  logic        rst, clk_en, flush, tile_en, wr_valid, start, data_out_ready;
  logic [16:0] wr_data;

  logic        wr_ready [2];
  logic [16:0] dout     [2];
  logic        vld      [2];
  logic        done     [2];
  logic [15:0] txc      [2];
  logic [1:0]  st       [2];

  int n_assert = 0;
  int n_fail   = 0;
  int model_cnt = 0;
  int c0, c1;

  logic [16:0] seq [$];
  logic [16:0] exp_q [2][$];
  logic        held_v [2];
  logic [16:0] held_d [2];

  always #5 clk = ~clk;

  stream_token_src #(.DEPTH(DEPTH), .TX_NUM(1)) dut0 (
    .clk(clk), .rst(rst), .clk_en(clk_en), .flush(flush), .tile_en(tile_en),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready[0]),
    .start(start), .data_out(dout[0]), .data_out_valid(vld[0]),
    .data_out_ready(data_out_ready), .done(done[0]), .tx_count(txc[0]),
    .state_dbg(st[0])
  );

  stream_token_src #(.DEPTH(DEPTH), .TX_NUM(2)) dut1 (
    .clk(clk), .rst(rst), .clk_en(clk_en), .flush(flush), .tile_en(tile_en),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready[1]),
    .start(start), .data_out(dout[1]), .data_out_valid(vld[1]),
    .data_out_ready(data_out_ready), .done(done[1]), .tx_count(txc[1]),
    .state_dbg(st[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: pops expected tokens on each accepted beat, and checks that a
  // stalled beat is presented unchanged on the next cycle.
  initial begin
    held_v[0] = 1'b0;
    held_v[1] = 1'b0;
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (held_v[k] && tile_en) begin
        check($sformatf("hold_valid%0d", k), 32'(vld[k]), 32'd1);
        check($sformatf("hold_data%0d", k), 32'(dout[k]), 32'(held_d[k]));
      end
      held_v[k] = 1'b0;
      if (vld[k] && !rst && !flush) begin
        if (data_out_ready && clk_en) begin
          if (exp_q[k].size() == 0)
            check($sformatf("extra_token%0d", k), 32'(exp_q[k].size()), 32'd1);
          else
            check($sformatf("token%0d", k), 32'(dout[k]), 32'(exp_q[k].pop_front()));
        end else begin
          held_v[k] = 1'b1;
          held_d[k] = dout[k];
        end
      end
    end
  end

  task automatic clear_exp();
    exp_q[0].delete();
    exp_q[1].delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    seq.delete();
    model_cnt = 0;
    clear_exp();
  endtask

  // Loads one token; the model accepts it only while fewer than DEPTH are held.
  task automatic load_tok(input logic [16:0] v);
    wr_valid = 1'b1;
    wr_data  = v;
    check("wr_ready0", 32'(wr_ready[0]), 32'(model_cnt < DEPTH));
    check("wr_ready1", 32'(wr_ready[1]), 32'(model_cnt < DEPTH));
    if (model_cnt < DEPTH) begin
      seq.push_back(v);
      model_cnt++;
    end
    tick();
    wr_valid = 1'b0;
  endtask

  // Expected stream for instance k: the loaded sequence k+1 times, then done.
  task automatic arm();
    clear_exp();
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r <= k; r++)
        foreach (seq[i]) exp_q[k].push_back(seq[i]);
      exp_q[k].push_back(DONE_TOK);
    end
  endtask

  // mode 0: ready always 1; mode 1: ready toggles, stray start; mode 2: random.
  task automatic play(input int mode, input bit do_start, output int cy0, output int cy1);
    cy0 = 0;
    cy1 = 0;
    if (do_start) begin
      start = 1'b1;
      data_out_ready = 1'b1;
      clk_en = 1'b1;
      tick();
      start = 1'b0;
    end
    for (int k = 1; k <= 400 && (cy0 == 0 || cy1 == 0); k++) begin
      case (mode)
        0: data_out_ready = 1'b1;
        1: begin
          data_out_ready = (k % 2 == 1);
          start = (k == 3);
        end
        default: begin
          data_out_ready = 1'($urandom_range(0, 1));
          clk_en = ($urandom_range(0, 3) != 0);
        end
      endcase
      tick();
      if (done[0] && cy0 == 0) cy0 = k;
      if (done[1] && cy1 == 0) cy1 = k;
    end
    start = 1'b0;
    clk_en = 1'b1;
    data_out_ready = 1'b1;
    check("done0_seen", 32'(done[0]), 32'd1);
    check("done1_seen", 32'(done[1]), 32'd1);
    check("drained0", 32'(exp_q[0].size()), 32'd0);
    check("drained1", 32'(exp_q[1].size()), 32'd0);
    check("tx_count0", 32'(txc[0]), 32'(seq.size() + 1));
    check("tx_count1", 32'(txc[1]), 32'(2 * seq.size() + 1));
    check("fin_valid0", 32'(vld[0]), 32'd0);
  endtask

  task automatic finish_to_idle();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("idle_done0", 32'(done[0]), 32'd0);
    check("idle_done1", 32'(done[1]), 32'd0);
    check("same_state", 32'(st[0]), 32'(st[1]));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; clk_en = 1'b0; flush = 1'b0; tile_en = 1'b1;
    wr_valid = 1'b0; wr_data = '0; start = 1'b0; data_out_ready = 1'b0;

    // Reset takes effect even with clk_en low.
    tick();
    check("rst_dout", 32'(dout[0]), 32'd0);
    check("rst_valid", 32'(vld[0]), 32'd0);
    check("rst_done", 32'(done[0]), 32'd0);
    check("rst_tx", 32'(txc[0]), 32'd0);
    clk_en = 1'b1;
    rst = 1'b0;
    tick();
    check("post_rst_dout", 32'(dout[1]), 32'd0);
    check("post_rst_valid", 32'(vld[1]), 32'd0);
    check("post_rst_wr_ready", 32'(wr_ready[0]), 32'd1);

    // tile_en low: no write ready, start ignored.
    tile_en = 1'b0;
    #1;
    check("tile_off_wr_ready", 32'(wr_ready[0]), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tile_en = 1'b1;
    tick();
    check("tile_off_start_ignored", 32'(vld[0]), 32'd0);

    // Mixed data/control sequence at full rate, then a replay.
    do_reset();
    load_tok(17'd3); load_tok(17'd5); load_tok(17'h10100); load_tok(17'd7);
    arm();
    play(0, 1'b1, c0, c1);
    check("full_rate_cycles0", 32'(c0), 32'd5);
    check("full_rate_cycles1", 32'(c1), 32'd9);
    finish_to_idle();
    arm();
    play(0, 1'b1, c0, c1);
    check("replay_cycles0", 32'(c0), 32'd5);
    finish_to_idle();

    // Toggling ready with a stray start during playback.
    do_reset();
    load_tok(17'd1); load_tok(17'd2);
    arm();
    play(1, 1'b1, c0, c1);
    check("toggle_cycles0", 32'(c0), 32'd5);
    check("toggle_cycles1", 32'(c1), 32'd9);

    // Empty buffer emits only the done token.
    do_reset();
    arm();
    play(0, 1'b1, c0, c1);
    check("empty_cycles0", 32'(c0), 32'd1);
    check("empty_cycles1", 32'(c1), 32'd1);

    // Overfill: 17th write dropped; random ready and clk_en; then replay.
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) load_tok(17'($urandom));
    check("full_wr_ready", 32'(wr_ready[0]), 32'd0);
    arm();
    play(2, 1'b1, c0, c1);
    finish_to_idle();
    arm();
    play(0, 1'b1, c0, c1);
    check("full_replay_cycles1", 32'(c1), 32'(2 * DEPTH + 1));

    // Flush after two of four tokens.
    do_reset();
    for (int i = 0; i < 4; i++) load_tok(17'($urandom_range(0, 17'h1FFFF)));
    arm();
    start = 1'b1; data_out_ready = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("mid_tx0", 32'(txc[0]), 32'd2);
    flush = 1'b1; data_out_ready = 1'b0;
    tick();
    flush = 1'b0;
    check("flush_valid0", 32'(vld[0]), 32'd0);
    check("flush_valid1", 32'(vld[1]), 32'd0);
    check("flush_tx0", 32'(txc[0]), 32'd0);
    clear_exp();
    flush = 1'b1; start = 1'b1;
    tick();
    flush = 1'b0; start = 1'b0;
    check("flush_beats_start", 32'(vld[0]), 32'd0);
    arm();
    play(0, 1'b1, c0, c1);
    check("after_flush_cycles0", 32'(c0), 32'd5);

    // Reset mid-PLAY: buffer forgotten, next start goes straight to done.
    do_reset();
    load_tok(17'd9); load_tok(17'd8); load_tok(17'd6);
    arm();
    start = 1'b1; data_out_ready = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1; data_out_ready = 1'b0;
    tick();
    rst = 1'b0;
    check("rst_mid_valid0", 32'(vld[0]), 32'd0);
    check("rst_mid_dout0", 32'(dout[0]), 32'd0);
    seq.delete();
    model_cnt = 0;
    arm();
    play(0, 1'b1, c0, c1);
    check("rst_mid_cycles0", 32'(c0), 32'd1);

    // tile_en low mid-PLAY freezes playback; it resumes at the same token.
    do_reset();
    for (int i = 0; i < 4; i++) load_tok(17'($urandom_range(0, 17'h1FFFF)));
    arm();
    start = 1'b1; data_out_ready = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tile_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("frozen_valid0", 32'(vld[0]), 32'd0);
    end
    check("frozen_tx0", 32'(txc[0]), 32'd1);
    tile_en = 1'b1;
    play(0, 1'b0, c0, c1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
